// File: rtl/module_serializer_if.sv
// Word handshake between an upstream producer and the serializer.
interface module_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/module_serializer.sv
// Parallel-to-serial framer: start(1), data LSB-first, optional parity, stop(0).
// Each bit is held BIT_CYCLES clocks; the line idles low.
module module_serializer #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                clk,
  input  logic                rst,
  module_serializer_if.slave  in_if,
  output logic                ser_out,
  output logic                busy,
  output logic                done
);
  localparam int CW = $clog2(BIT_CYCLES) + 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_PRE  = CW'((BIT_CYCLES > 1) ? BIT_CYCLES - 2 : 0);
  localparam logic          PRE_EN   = (BIT_CYCLES > 1);
  localparam logic          DONE_NOW = (BIT_CYCLES == 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic             par_q;
  logic [BW-1:0]    bit_q;
  logic [CW-1:0]    cyc_q;
  logic             ser_q, busy_q, done_q;

  logic             cyc_last;
  logic [WIDTH-1:0] shr;

  assign cyc_last       = (cyc_q == CYC_LAST);
  assign shr            = shreg_q >> 1;
  assign in_if.in_ready = (state_q == S_IDLE) && !rst;

  assign ser_out = ser_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // ser_q is loaded with the value of the state being entered, so every
  // serial bit is a registered output aligned with its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
      cyc_q   <= '0;
      ser_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE) cyc_q <= cyc_last ? '0 : cyc_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (in_if.in_valid) begin
            state_q <= S_START;
            shreg_q <= in_if.in_data;
            par_q   <= (^in_if.in_data) ^ 1'(PARITY_ODD);
            bit_q   <= '0;
            cyc_q   <= '0;
            ser_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cyc_last) begin
            state_q <= S_DATA;
            bit_q   <= '0;
            ser_q   <= shreg_q[0];
          end
        end
        S_DATA: begin
          if (cyc_last) begin
            if (bit_q == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                state_q <= S_PARITY;
                ser_q   <= par_q;
              end else begin
                state_q <= S_STOP;
                ser_q   <= 1'b0;
                done_q  <= DONE_NOW;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              shreg_q <= shr;
              ser_q   <= shr[0];
            end
          end
        end
        S_PARITY: begin
          if (cyc_last) begin
            state_q <= S_STOP;
            ser_q   <= 1'b0;
            done_q  <= DONE_NOW;
          end
        end
        S_STOP: begin
          // done is registered, so it is raised one clock before the final stop clock
          if (cyc_last) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (PRE_EN && (cyc_q == CYC_PRE)) begin
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ser_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_module_serializer.sv
// Bench for module_serializer: three configurations, fixed vectors, corner
// sequences and random words checked against a frame model.
module tb_module_serializer;
  localparam int ND = 3;
  localparam int WD[ND]   = '{8, 8, 5};
  localparam int BCY[ND]  = '{1, 3, 2};
  localparam int PEN[ND]  = '{0, 1, 1};
  localparam int PODD[ND] = '{0, 0, 1};

  typedef struct {
    logic [7:0] d;
    logic [9:0] exp;  // exp[k] = ser_out on clock k after accept
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dat [ND];
  logic       vld [ND];
  logic       rdy [ND];
  logic       ser [ND];
  logic       busy[ND];
  logic       done[ND];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  module_serializer_if #(.WIDTH(8)) ifa ();
  module_serializer_if #(.WIDTH(8)) ifb ();
  module_serializer_if #(.WIDTH(5)) ifc ();

  assign ifa.in_data  = dat[0];
  assign ifa.in_valid = vld[0];
  assign rdy[0]       = ifa.in_ready;
  assign ifb.in_data  = dat[1];
  assign ifb.in_valid = vld[1];
  assign rdy[1]       = ifb.in_ready;
  assign ifc.in_data  = dat[2][4:0];
  assign ifc.in_valid = vld[2];
  assign rdy[2]       = ifc.in_ready;

  module_serializer #(.WIDTH(8), .BIT_CYCLES(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .in_if(ifa), .ser_out(ser[0]), .busy(busy[0]), .done(done[0]));
  module_serializer #(.WIDTH(8), .BIT_CYCLES(3), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst(rst), .in_if(ifb), .ser_out(ser[1]), .busy(busy[1]), .done(done[1]));
  module_serializer #(.WIDTH(5), .BIT_CYCLES(2), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
    .clk(clk), .rst(rst), .in_if(ifc), .ser_out(ser[2]), .busy(busy[2]), .done(done[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame model: bit b of the frame is start/data/parity/stop, each held BCY clocks.
  function automatic int frame_len(input int d);
    return (2 + WD[d] + PEN[d]) * BCY[d];
  endfunction

  function automatic logic [63:0] model_frame(input int d, input logic [7:0] w);
    logic [63:0] r;
    logic        p, b_v;
    int          nb;
    r  = '0;
    nb = 2 + WD[d] + PEN[d];
    p  = PODD[d][0];
    for (int i = 0; i < WD[d]; i++) p = p ^ w[i];
    for (int b = 0; b < nb; b++) begin
      if (b == 0)                             b_v = 1'b1;
      else if (b <= WD[d])                    b_v = w[b-1];
      else if (PEN[d] != 0 && b == WD[d] + 1) b_v = p;
      else                                    b_v = 1'b0;
      for (int c = 0; c < BCY[d]; c++) r[b*BCY[d] + c] = b_v;
    end
    return r;
  endfunction

  // Called just after the accepting posedge; ends on the negedge of the idle clock.
  task automatic check_frame(input int d, input logic [63:0] eb, input int len,
                             input logic [7:0] nd, input logic nv, input string nm);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k == 0) begin dat[d] = nd; vld[d] = nv; end
      chk(nm, {ser[d], busy[d], done[d], rdy[d]}, {eb[k], 1'b1, (k == len - 1), 1'b0});
    end
    @(negedge clk);
    chk({nm, "_idle"}, {ser[d], busy[d], done[d], rdy[d]}, 4'b0001);
  endtask

  task automatic send(input int d, input logic [7:0] w, input logic [63:0] eb, input int len,
                      input string nm, input logic [7:0] nd, input logic nv);
    int n;
    dat[d] = w;
    vld[d] = 1'b1;
    n = 0;
    while (!rdy[d] && n < 50) begin @(negedge clk); n++; end
    chk({nm, "_rdy"}, 32'(rdy[d]), 32'd1);
    @(posedge clk);
    check_frame(d, eb, len, nd, nv, nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    int   bcnt, didx, ndone, gap;
    logic [2:0] pbits;
    logic [7:0] w;

    tbl[0] = '{d: 8'hA5, exp: 10'b0101001011};
    tbl[1] = '{d: 8'h3C, exp: 10'b0001111001};
    tbl[2] = '{d: 8'hFF, exp: 10'b0111111111};
    tbl[3] = '{d: 8'h01, exp: 10'b0000000011};
    tbl[4] = '{d: 8'h00, exp: 10'b0000000001};

    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin dat[d] = '0; vld[d] = 1'b0; end

    // reset and idle line
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) chk("reset", {ser[d], busy[d], done[d], rdy[d]}, 4'b0000);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) chk("idle", {ser[d], busy[d], done[d], rdy[d]}, 4'b0001);
    end

    // fixed vectors on the default configuration
    for (int i = 0; i < 5; i++)
      send(0, tbl[i].d, {54'b0, tbl[i].exp}, 10, $sformatf("vec%0d", i), 8'($urandom), 1'b0);

    // in_valid held: 0x01 then 0xFF, one idle clock between, mid-frame data change ignored
    send(0, 8'h01, {54'b0, tbl[3].exp}, 10, "b2b_first", 8'hFF, 1'b1);
    send(0, 8'hFF, {54'b0, tbl[2].exp}, 10, "b2b_second", 8'h00, 1'b0);

    // 0x07, 3 clocks per bit, even parity
    dat[1] = 8'h07; vld[1] = 1'b1;
    @(posedge clk);
    bcnt = 0; didx = -1; ndone = 0; pbits = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) vld[1] = 1'b0;
      if (busy[1]) bcnt++;
      if (done[1]) begin didx = k; ndone++; end
      if (k >= 27 && k <= 29) pbits[k-27] = ser[1];
    end
    chk("par_busy_len", 32'(bcnt), 32'd33);
    chk("par_done_clk", 32'(didx), 32'd32);
    chk("par_done_cnt", 32'(ndone), 32'd1);
    chk("par_bit", 32'(pbits), 32'h7);

    // reset in the middle of a frame
    dat[0] = 8'hA5; vld[0] = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) vld[0] = 1'b0;
      chk("abort_pre", {ser[0], busy[0], done[0], rdy[0]}, {tbl[0].exp[k], 3'b100});
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst", {ser[0], busy[0], done[0], rdy[0]}, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_after", {ser[0], busy[0], done[0], rdy[0]}, 4'b0001);
    send(0, 8'h3C, {54'b0, tbl[1].exp}, 10, "abort_next", 8'h00, 1'b0);

    // rst and in_valid together: no accept
    rst = 1'b1; vld[0] = 1'b1; dat[0] = 8'h55;
    @(negedge clk);
    chk("rst_wins", {ser[0], busy[0], done[0], rdy[0]}, 4'b0000);
    rst = 1'b0; vld[0] = 1'b0;
    @(negedge clk);
    chk("rst_wins_after", {ser[0], busy[0], done[0], rdy[0]}, 4'b0001);

    // random words with random idle gaps on every configuration
    for (int d = 0; d < ND; d++) begin
      repeat (25) begin
        w   = 8'($urandom);
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          @(negedge clk);
          chk("rand_gap", {ser[d], busy[d], done[d], rdy[d]}, 4'b0001);
        end
        send(d, w, model_frame(d, w), frame_len(d), $sformatf("rand_d%0d_%02h", d, w),
             8'($urandom), 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
